// File: rtl/inst_fetch_bridge_pkg.sv
// Shared widths, constants and state encoding for the instruction-fetch bridge.
package inst_fetch_bridge_pkg;
   localparam int unsigned InstAddressBus = 32;
   localparam int unsigned InstDataBus    = 32;
   localparam logic [InstDataBus-1:0] ZeroWord = '0;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fetch_state_e;
endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating wait counter for an outstanding fetch; tc_o flags the last allowed request cycle.
module fetch_timeout_ctr #(
   parameter int unsigned WIDTH = 6,
   parameter int unsigned LAST  = 63
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [WIDTH-1:0] LastVal = WIDTH'(LAST);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == LastVal);

   // Holding at the terminal value guarantees the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !tc_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

// File: rtl/inst_fetch_bridge.sv
// Single-entry tagged fetch buffer bridging the core fetch port to a req/ack instruction memory.
module inst_fetch_bridge
   import inst_fetch_bridge_pkg::*;
#(
   parameter int unsigned                  TIMEOUT_CYCLES = 64,
   parameter logic [InstDataBus-1:0]       NOP_INST       = ZeroWord
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       ce_i,
   input  logic [InstAddressBus-1:0]  addr_i,
   input  logic                       flush_i,
   output logic [InstDataBus-1:0]     data_o,
   output logic                       stall_req_o,
   output logic                       mem_req_o,
   output logic [InstAddressBus-1:0]  mem_addr_o,
   input  logic                       mem_ack_i,
   input  logic [InstDataBus-1:0]     mem_rdata_i,
   output logic                       err_o
);
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   fetch_state_e                     state_q, state_d;
   logic                             valid_q, valid_d;
   logic [InstAddressBus-1:2]        tag_q, tag_d;
   logic [InstDataBus-1:0]           data_q, data_d;
   logic                             mem_req_q, mem_req_d;
   logic [InstAddressBus-1:0]        mem_addr_q, mem_addr_d;
   logic                             err_q, err_d;
   logic                             ctr_clr, ctr_en, ctr_tc;
   logic                             hit;

   // Byte offset within the word plays no part in fetching.
   logic unused_byte_offset;
   assign unused_byte_offset = &{1'b0, addr_i[1:0]};

   assign hit         = valid_q && (tag_q == addr_i[InstAddressBus-1:2]);
   assign data_o      = (ce_i && hit) ? data_q : ZeroWord;
   assign stall_req_o = ce_i && !hit;
   assign mem_req_o   = mem_req_q;
   assign mem_addr_o  = mem_addr_q;
   assign err_o       = err_q;

   fetch_timeout_ctr #(
      .WIDTH (CntW),
      .LAST  (TIMEOUT_CYCLES - 1)
   ) u_timeout_ctr (
      .clk   (clk),
      .rst   (rst),
      .clr_i (ctr_clr),
      .en_i  (ctr_en),
      .tc_o  (ctr_tc)
   );

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      tag_d      = tag_q;
      data_d     = data_q;
      mem_req_d  = mem_req_q;
      mem_addr_d = mem_addr_q;
      err_d      = 1'b0;
      ctr_clr    = 1'b0;
      ctr_en     = 1'b0;
      case (state_q)
         IDLE: begin
            if (flush_i) begin
               valid_d = 1'b0;
            end else if (ce_i && !hit) begin
               mem_addr_d = {addr_i[InstAddressBus-1:2], 2'b00};
               mem_req_d  = 1'b1;
               ctr_clr    = 1'b1;
               state_d    = BUSY;
            end
         end
         BUSY: begin
            // Flush outranks a same-cycle ack so stale data never lands in the buffer.
            if (flush_i) begin
               valid_d   = 1'b0;
               mem_req_d = 1'b0;
               state_d   = IDLE;
            end else if (mem_ack_i || ctr_tc) begin
               data_d    = mem_ack_i ? mem_rdata_i : NOP_INST;
               tag_d     = mem_addr_q[InstAddressBus-1:2];
               valid_d   = 1'b1;
               mem_req_d = 1'b0;
               err_d     = !mem_ack_i;
               state_d   = IDLE;
            end else begin
               ctr_en = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         valid_q    <= 1'b0;
         tag_q      <= '0;
         data_q     <= ZeroWord;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         tag_q      <= tag_d;
         data_q     <= data_d;
         mem_req_q  <= mem_req_d;
         mem_addr_q <= mem_addr_d;
         err_q      <= err_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Directed bench for inst_fetch_bridge: each task drives one scenario and checks against hand-computed values.
module tb_inst_fetch_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic        flush_i = 1'b0;
   logic [31:0] data_o;
   logic        stall_req_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        err_o;

   int checks = 0;
   int errors = 0;

   inst_fetch_bridge #(.TIMEOUT_CYCLES(4), .NOP_INST(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .ce_i        (ce_i),
      .addr_i      (addr_i),
      .flush_i     (flush_i),
      .data_o      (data_o),
      .stall_req_o (stall_req_o),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   // Advance one cycle; inputs change and outputs are sampled well after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", mem_addr_o); end
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err_o); end
      checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 00000000", data_o); end
      checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL rst_stall_ce0 got %0b exp 0", stall_req_o); end
      ce_i = 1'b1; #1;
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL rst_stall_ce1 got %0b exp 1", stall_req_o); end
      ce_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      $display("test_reset done");
   endtask

   task automatic test_miss_fill();
      ce_i = 1'b1; addr_i = 32'h0; #1;
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL t1_stall_c0 got %0b exp 1", stall_req_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t1_req_c0 got %0b exp 0", mem_req_o); end
      tick();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t1_req_c1 got %0b exp 1", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL t1_addr got %h exp 00000000", mem_addr_o); end
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL t1_stall_c1 got %0b exp 1", stall_req_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h3401_1100;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
      checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL t1_stall_c2 got %0b exp 0", stall_req_o); end
      checks++; if (data_o !== 32'h3401_1100) begin errors++; $display("FAIL t1_data got %h exp 34011100", data_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t1_req_c2 got %0b exp 0", mem_req_o); end
      $display("test_miss_fill done");
   endtask

   task automatic test_hit();
      addr_i = 32'h0; #1;
      checks++; if (data_o !== 32'h3401_1100) begin errors++; $display("FAIL t2_data0 got %h exp 34011100", data_o); end
      tick();
      addr_i = 32'h2; #1;
      checks++; if (data_o !== 32'h3401_1100) begin errors++; $display("FAIL t2_data2 got %h exp 34011100", data_o); end
      checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL t2_stall got %0b exp 0", stall_req_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_a got %0b exp 0", mem_req_o); end
      tick();
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t2_req_b got %0b exp 0", mem_req_o); end
      ce_i = 1'b0; #1;
      checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL t2_data_ce0 got %h exp 00000000", data_o); end
      $display("test_hit done");
   endtask

   task automatic test_addr_change_busy();
      ce_i = 1'b1; addr_i = 32'h4;
      tick();
      checks++; if (mem_addr_o !== 32'h4) begin errors++; $display("FAIL t3_addr got %h exp 00000004", mem_addr_o); end
      addr_i = 32'h8;
      tick();
      checks++; if (mem_addr_o !== 32'h4) begin errors++; $display("FAIL t3_addr_hold got %h exp 00000004", mem_addr_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'hAAAA_5555;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      addr_i = 32'h4; #1;
      checks++; if (data_o !== 32'hAAAA_5555) begin errors++; $display("FAIL t3_tag4 got %h exp aaaa5555", data_o); end
      addr_i = 32'h8; #1;
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL t3_miss8 got %0b exp 1", stall_req_o); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t3_req_idle got %0b exp 0", mem_req_o); end
      tick();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t3_req8 got %0b exp 1", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h8) begin errors++; $display("FAIL t3_addr8 got %h exp 00000008", mem_addr_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
      checks++; if (data_o !== 32'h1234_5678) begin errors++; $display("FAIL t3_data8 got %h exp 12345678", data_o); end
      $display("test_addr_change_busy done");
   endtask

   task automatic test_timeout();
      addr_i = 32'hC;
      tick();
      for (int k = 1; k <= 4; k++) begin
         checks++; if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL t4_req_cycle%0d got req=%0b err=%0b exp req=1 err=0", k, mem_req_o, err_o); end
         tick();
      end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t4_req_drop got %0b exp 0", mem_req_o); end
      checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL t4_err got %0b exp 1", err_o); end
      checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL t4_stall got %0b exp 0", stall_req_o); end
      checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL t4_nop got %h exp 00000000", data_o); end
      tick();
      checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL t4_err_pulse got %0b exp 0", err_o); end
      $display("test_timeout done");
   endtask

   task automatic test_flush_ack();
      addr_i = 32'h10;
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; flush_i = 1'b1;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; flush_i = 1'b0; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t5_req_drop got %0b exp 0", mem_req_o); end
      checks++; if (stall_req_o !== 1'b1 || data_o !== 32'h0) begin errors++; $display("FAIL t5_discard got stall=%0b data=%h exp stall=1 data=00000000", stall_req_o, data_o); end
      addr_i = 32'hC; #1;
      checks++; if (stall_req_o !== 1'b1) begin errors++; $display("FAIL t5_invalid got %0b exp 1", stall_req_o); end
      addr_i = 32'h10;
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10) begin errors++; $display("FAIL t5_reissue got req=%0b addr=%h exp req=1 addr=00000010", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
      checks++; if (data_o !== 32'h0BAD_F00D) begin errors++; $display("FAIL t5_data got %h exp 0badf00d", data_o); end
      // Flush coinciding with a miss in IDLE defers the request by one cycle.
      addr_i = 32'h14; flush_i = 1'b1;
      tick();
      flush_i = 1'b0; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t5_flush_miss got %0b exp 0", mem_req_o); end
      tick();
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h14) begin errors++; $display("FAIL t5_deferred got req=%0b addr=%h exp req=1 addr=00000014", mem_req_o, mem_addr_o); end
      mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
      $display("test_flush_ack done");
   endtask

   task automatic test_idle_ack();
      ce_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; ce_i = 1'b1; addr_i = 32'h14; #1;
      checks++; if (data_o !== 32'h5555_AAAA || mem_req_o !== 1'b0) begin errors++; $display("FAIL t_idle_ack got data=%h req=%0b exp data=5555aaaa req=0", data_o, mem_req_o); end
      $display("test_idle_ack done");
   endtask

   task automatic test_reset_midflight();
      addr_i = 32'h20;
      tick();
      checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL t6_req got %0b exp 1", mem_req_o); end
      rst = 1'b1; #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL t6_async_drop got %0b exp 0", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL t6_addr got %h exp 00000000", mem_addr_o); end
      checks++; if (stall_req_o !== 1'b1 || data_o !== 32'h0) begin errors++; $display("FAIL t6_outputs got stall=%0b data=%h exp stall=1 data=00000000", stall_req_o, data_o); end
      ce_i = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
      tick();
      mem_ack_i = 1'b0; mem_rdata_i = 32'h0; #1;
      checks++; if (mem_req_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL t6_late_ack got req=%0b err=%0b exp req=0 err=0", mem_req_o, err_o); end
      ce_i = 1'b1; addr_i = 32'h20; #1;
      checks++; if (stall_req_o !== 1'b1 || data_o !== 32'h0) begin errors++; $display("FAIL t6_no_capture got stall=%0b data=%h exp stall=1 data=00000000", stall_req_o, data_o); end
      ce_i = 1'b0;
      $display("test_reset_midflight done");
   endtask

   initial begin
      test_reset();
      test_miss_fill();
      test_hit();
      test_addr_change_busy();
      test_timeout();
      test_flush_ack();
      test_idle_ack();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/inst_fetch_bridge.md
# inst_fetch_bridge

- Sits between the core's instruction-fetch port (`rom_ce_o`/`rom_addr_o`/`rom_data_i`) and a variable-latency instruction memory with a req/ack handshake.
- Holds the last fetched word with its address tag, so a repeated fetch costs nothing; any other fetch starts a memory transaction and raises a stall request toward the pipeline controller.
- A bounded wait, set by a parameter, keeps a dead memory from hanging the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles `mem_req_o` stays high without `mem_ack_i`; legal range 2..65535.
- `NOP_INST`, default 32'h0000_0000: word returned on timeout.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ce_i`  in  1  core fetch enable (driven from `rom_ce_o`).
- `addr_i`  in  32  core fetch address (driven from `rom_addr_o`).
- `flush_i`  in  1  invalidates the held word; discards any in-flight result.
- `data_o`  out  32  instruction to the core (drives `rom_data_i`).
- `stall_req_o`  out  1  fetch not yet satisfied; the core must hold the PC.
- `mem_req_o`  out  1  memory request, level, registered.
- `mem_addr_o`  out  32  word-aligned request address, registered.
- `mem_ack_i`  in  1  one-cycle acknowledge; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i`  in  32  memory read data.
- `err_o`  out  1  one-cycle pulse on timeout.

## Operation
State and hit rule:
- State: `IDLE`, `BUSY`. Held registers: `valid`, `tag[31:2]`, `data[31:0]`, `cnt`.
- `hit = valid && tag == addr_i[31:2]`. `addr_i[1:0]` is ignored everywhere.

Combinational outputs:
- `data_o = (ce_i && hit) ? data : 0`.
- `stall_req_o = ce_i && !hit`.
- While `ce_i = 0`: `data_o = 0`, `stall_req_o = 0`.

Transitions:
- `IDLE`: if `ce_i && !hit && !flush_i`, load `mem_addr_o = {addr_i[31:2], 2'b00}`, set `mem_req_o = 1`, clear `cnt`, go to `BUSY`.
- `BUSY`, `mem_ack_i`: set `data = mem_rdata_i`, `tag = mem_addr_o[31:2]`, `valid = 1`, `mem_req_o = 0`, go to `IDLE`.
- `BUSY`, no ack, `cnt == TIMEOUT_CYCLES-1`: set `data = NOP_INST`, `tag = mem_addr_o[31:2]`, `valid = 1`, `mem_req_o = 0`, pulse `err_o`, go to `IDLE`.
- `BUSY`, otherwise: increment `cnt`.
- `flush_i` (any state): `valid = 0`. In `BUSY`, `mem_req_o` drops, go to `IDLE`, no capture.

Boundary conditions:
- `flush_i` and `mem_ack_i` in the same cycle: flush wins and the data is discarded.
- `flush_i` together with a miss in `IDLE`: no request that cycle; the miss issues on the following cycle.
- `addr_i` changing during `BUSY`: ignored; the transaction completes for the latched address, then the new address misses.
- `ce_i` falling during `BUSY`: the transaction still completes and fills the held word.
- `mem_ack_i` in `IDLE`: ignored.
- `mem_addr_o` holds its last value when `mem_req_o = 0`.
- Reset mid-transaction: `mem_req_o` drops asynchronously; a later ack is ignored.

## Timing
- Reset values: state `IDLE`, `valid = 0`, `tag = 0`, `data = 0`, `cnt = 0`, `mem_req_o = 0`, `mem_addr_o = 0`, `err_o = 0`.
- Since `valid = 0` after reset, `data_o = 0` and `stall_req_o = ce_i`.
- Hit: zero latency; `data_o` is valid in the same cycle as `addr_i`.
- Miss detected in cycle N: `mem_req_o` is high from N+1.
- Ack in cycle M ≥ N+1: `data_o` valid and `stall_req_o` low from M+1.
- Minimum miss penalty: 2 stall cycles.
- Timeout: `mem_req_o` high for exactly `TIMEOUT_CYCLES` cycles. `err_o` is high in the cycle after the last request cycle, and the NOP is delivered in that same cycle.
- `cnt` width: `$clog2(TIMEOUT_CYCLES)`; it never wraps.

## Structure
- Bus widths (`InstAddressBus`, `InstDataBus`), `ZeroWord` and the state encoding go in the shared define file. Default `NOP_INST` equals `ZeroWord`.
- Natural sub-module: `fetch_timeout_ctr`, containing clear, enable and a terminal-count output.
- The held-word register, tag compare and FSM stay in the top of this block.

## Test plan
1. Reset, then `ce_i = 1`, `addr_i = 0x0`, memory acks 1 cycle after request with `0x34011100` -> `stall_req_o` high for 2 cycles, `mem_addr_o = 0x0`, then `data_o = 0x34011100`, `stall_req_o = 0`.
2. Repeat `addr_i = 0x0` after fill, then `addr_i = 0x2` -> no new `mem_req_o`, `data_o = 0x34011100` both cycles.
3. Miss on `0x4`, `addr_i` changes to `0x8` during `BUSY`, ack returns `0xAAAA5555` -> tag becomes `0x4`, then a new request to `0x8` starts the cycle after `IDLE` is re-entered.
4. `TIMEOUT_CYCLES = 4`, no ack -> `mem_req_o` high for 4 cycles, `err_o` single-cycle pulse, `data_o = 0x00000000`, stall released.
5. `flush_i` asserted in the same cycle as `mem_ack_i` -> data discarded, `valid = 0`, a new request is issued for the same address.
6. `rst` asserted while `mem_req_o = 1`, ack arrives after reset release -> `mem_req_o = 0` immediately, ack ignored, all outputs at reset values.
